// File: rtl/eq_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eq_stream_pkg
//  Brief    : Shared types and constants for the equality stream checker:
//             the lock FSM state enum and the run-length counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package eq_stream_pkg;

    // Width of the consecutive-match run counter presented on run_cnt.
    localparam int RUN_CNT_W = 8;

    // Lock tracking states.
    //   IDLE   : nothing accepted since reset/clear
    //   HUNT   : pairs seen, run of matches not yet long enough
    //   LOCKED : run of matches has reached RUN_LEN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } eq_state_e;

endpackage : eq_stream_pkg
`default_nettype wire

// File: rtl/eq_stream_checker_eq.sv
`default_nettype none
// ============================================================================
//  Module   : DataFlowLogicalEQ
//  Brief    : Pure combinational N-bit equality compare (a == b).
//  Revision : 1.0 - initial release
// ============================================================================
module DataFlowLogicalEQ #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    // Dataflow compare; the result register lives in the parent.
    assign eq = (a == b);

endmodule : DataFlowLogicalEQ
`default_nettype wire

// File: rtl/eq_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : eq_stream_checker
//  Brief    : Valid/ready stream of operand pairs, compared for equality with
//             a one-cycle registered result. Tracks the run of consecutive
//             matches and reports lock once the run reaches RUN_LEN.
//             Optional match / mismatch statistics counters are built only
//             when EQ_STREAM_CHECKER_STATS_EN is defined; otherwise the
//             counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module eq_stream_checker
    import eq_stream_pkg::*;
#(
    parameter int N       = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_eq,
    output logic                 locked,
    output logic [RUN_CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt
);

    localparam logic [RUN_CNT_W-1:0] C_RUN_LEN = RUN_CNT_W'(RUN_LEN);
    localparam logic [RUN_CNT_W-1:0] C_RUN_ONE = RUN_CNT_W'(1);

    logic                 w_eq;
    logic                 w_accept;

    logic                 out_valid_q, out_valid_d;
    logic                 out_eq_q,    out_eq_d;
    logic [RUN_CNT_W-1:0] run_cnt_q,   run_cnt_d;
    eq_state_e            state_q,     state_d;

    // The output slot can take a new pair when empty or being drained now.
    // A clear drops whatever is offered in the same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready && !clr;

    DataFlowLogicalEQ #(
        .N (N)
    ) u_eq (
        .a  (a),
        .b  (b),
        .eq (w_eq)
    );

    // Result slot: load on accept, empty on drain, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_eq_d    = out_eq_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_eq_d    = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_eq_d    = w_eq;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Lock FSM and run counter; both advance only on accepted pairs.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (clr) begin
            state_d   = IDLE;
            run_cnt_d = '0;
        end else if (w_accept) begin
            if (w_eq) begin
                run_cnt_d = (run_cnt_q >= C_RUN_LEN) ? C_RUN_LEN
                                                     : run_cnt_q + C_RUN_ONE;
            end else begin
                run_cnt_d = '0;
            end
            case (state_q)
                IDLE, HUNT: state_d = (run_cnt_d == C_RUN_LEN) ? LOCKED : HUNT;
                LOCKED:     state_d = w_eq ? LOCKED : HUNT;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Result, run and state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_eq_q    <= 1'b0;
            run_cnt_q   <= '0;
            state_q     <= IDLE;
        end else begin
            out_valid_q <= out_valid_d;
            out_eq_q    <= out_eq_d;
            run_cnt_q   <= run_cnt_d;
            state_q     <= state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_eq    = out_eq_q;
    assign run_cnt   = run_cnt_q;
    // Lock is a decode of the registered state, so it moves on the same
    // edge that loads the out_eq of the pair that caused the transition.
    assign locked    = (state_q == LOCKED);

`ifdef EQ_STREAM_CHECKER_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] match_cnt_q,    match_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;

    // Saturating totals of accepted matching / non-matching pairs.
    always_comb begin
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        if (clr) begin
            match_cnt_d    = '0;
            mismatch_cnt_d = '0;
        end else if (w_accept) begin
            if (w_eq) begin
                if (match_cnt_q != C_CNT_MAX) begin
                    match_cnt_d = match_cnt_q + C_CNT_ONE;
                end
            end else begin
                if (mismatch_cnt_q != C_CNT_MAX) begin
                    mismatch_cnt_d = mismatch_cnt_q + C_CNT_ONE;
                end
            end
        end
    end

    // Statistics registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign match_cnt    = match_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
`else
    assign match_cnt    = '0;
    assign mismatch_cnt = '0;
`endif

endmodule : eq_stream_checker
`default_nettype wire
